// File: rtl/as_pack.sv
// Shared definitions for the as_* UART blocks: word width, transmitter FSM
// states and the minimum usable baud divider.
package as_pack;

  localparam int uart_width   = 8;
  localparam int UART_MIN_DIV = 2;

  typedef enum logic [2:0] {
    IDLE_ST,
    START_ST,
    DATA_ST,
    PAR_ST,
    STOP_ST
  } tx_state_t;

endpackage

// File: rtl/as_tx_sync_fifo.sv
// Single-clock write FIFO. Write-side accept and read-side pop are each
// guarded by the registered count, so a pop never frees a slot for a write
// in the same cycle. Read data is the current head word (combinational).
module as_tx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push    = wr_i && !full_o;
  assign pop     = rd_i && !empty_o;
  assign rdata_o = mem[rd_ptr_q];

  // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch is never inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array written on accepted pushes.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is deliberately not reset; validity is tracked by count, so clearing the array would only cost reset fan-out.
    if (push) mem[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/as_tx_fifo_uart.sv
// UART transmitter with a small write FIFO: 1 start bit, uart_width data bits
// LSB first, optional even parity, 1 stop bit. Divider and parity enable are
// captured at frame start; back-to-back frames have no idle gap.
module as_tx_fifo_uart
  import as_pack::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [uart_width-1:0] data_i,
  input  logic                  wr_i,
  input  logic [DIV_W-1:0]      div_i,
  input  logic                  par_en_i,
  input  logic                  clr_ovf_i,
  output logic                  tx_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ovf_o
);

  localparam int                IDX_W    = $clog2(uart_width);
  localparam logic [IDX_W-1:0]  LAST_BIT = IDX_W'(uart_width - 1);

  tx_state_t             state_q, state_d;
  logic [DIV_W-1:0]      cnt_q, cnt_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [uart_width-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic                  par_en_q, par_en_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  ovf_q, ovf_d;

  logic                  fifo_rd;
  logic [uart_width-1:0] fifo_rdata;
  logic                  fifo_full, fifo_empty;
  logic [DIV_W-1:0]      div_eff;
  logic                  bit_end;
  logic                  load;

  as_tx_sync_fifo #(
    .WIDTH (uart_width),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .wr_i    (wr_i),
    .wdata_i (data_i),
    .rd_i    (fifo_rd),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Divider values below the minimum would give zero-length bits.
  assign div_eff = (div_i < DIV_W'(UART_MIN_DIV)) ? DIV_W'(UART_MIN_DIV) : div_i;
  assign bit_end = (cnt_q == '0);

  assign tx_o    = tx_q;
  assign full_o  = fifo_full;
  assign empty_o = fifo_empty;
  assign busy_o  = (state_q != IDLE_ST);
  assign ovf_o   = ovf_q;

  // Frame FSM, baud counter, shift register and the next value of the line.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    par_en_d  = par_en_q;
    parity_d  = parity_q;
    fifo_rd   = 1'b0;
    done_o    = 1'b0;
    load      = 1'b0;
    tx_d      = 1'b1;

    if (state_q != IDLE_ST) cnt_d = bit_end ? div_q - DIV_W'(1) : cnt_q - DIV_W'(1);

    unique case (state_q)
      IDLE_ST:  if (!fifo_empty) load = 1'b1;
      START_ST: if (bit_end) state_d = DATA_ST;
      DATA_ST: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == LAST_BIT) state_d = par_en_q ? PAR_ST : STOP_ST;
        end
      end
      PAR_ST:   if (bit_end) state_d = STOP_ST;
      STOP_ST: begin
        done_o = bit_end;
        if (bit_end) begin
          if (!fifo_empty) load = 1'b1;
          else             state_d = IDLE_ST;
        end
      end
      default:  state_d = IDLE_ST;
    endcase

    // Frame start: pop the head word and capture this frame's settings.
    if (load) begin
      fifo_rd   = 1'b1;
      state_d   = START_ST;
      shift_d   = fifo_rdata;
      div_d     = div_eff;
      cnt_d     = div_eff - DIV_W'(1);
      par_en_d  = par_en_i;
      parity_d  = ^fifo_rdata;
      bit_idx_d = '0;
    end

    // Line level follows the state being entered, so tx_q is glitch-free.
    unique case (state_d)
      START_ST: tx_d = 1'b0;
      DATA_ST:  tx_d = shift_d[0];
      PAR_ST:   tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase

    // Overflow is sticky; a new overflow wins over a simultaneous clear.
    if (wr_i && fifo_full) ovf_d = 1'b1;
    else if (clr_ovf_i)    ovf_d = 1'b0;
    else                   ovf_d = ovf_q;
  end

  // State registers; reset aborts any frame and forces the line idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE_ST;
      cnt_q     <= '0;
      div_q     <= DIV_W'(UART_MIN_DIV);
      shift_q   <= '0;
      bit_idx_q <= '0;
      par_en_q  <= 1'b0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      par_en_q  <= par_en_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_as_tx_fifo_uart.sv
// Bench for as_tx_fifo_uart: a frame-timeline reference model checked every
// cycle, table-driven single-frame vectors, hand-written corner sequences and
// randomized traffic.
module tb_as_tx_fifo_uart;

  localparam int FIFO_DEPTH = 4;
  localparam int DIV_W      = 16;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [7:0]       data_i;
  logic             wr_i;
  logic [DIV_W-1:0] div_i;
  logic             par_en_i;
  logic             clr_ovf_i;
  logic             tx_o, full_o, empty_o, busy_o, done_o, ovf_o;

  int n_tests = 0;
  int n_fail  = 0;

  as_tx_fifo_uart #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (DIV_W)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .data_i    (data_i),
    .wr_i      (wr_i),
    .div_i     (div_i),
    .par_en_i  (par_en_i),
    .clr_ovf_i (clr_ovf_i),
    .tx_o      (tx_o),
    .full_o    (full_o),
    .empty_o   (empty_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .ovf_o     (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model: queue of words + frame timeline ----------------
  logic [7:0] m_q[$];
  int         m_rem = 0;   // clocks left in current frame, including the present one
  int         m_len = 0;
  int         m_d   = 2;
  bit         m_par = 1'b0;
  logic [7:0] m_word = '0;
  bit         m_ovf = 1'b0;
  bit         m_full, m_start;

  function automatic logic exp_tx();
    int idx;
    if (m_rem == 0) return 1'b1;
    idx = (m_len - m_rem) / m_d;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_word[idx-1];
    if (idx == 9 && m_par) return ^m_word;
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge clk_i or negedge rst_ni);
    if (!rst_ni) begin
      m_q.delete();
      m_rem = 0;
      m_ovf = 1'b0;
    end else begin
      m_full  = (m_q.size() == FIFO_DEPTH);
      m_start = 1'b0;
      if (m_rem == 0)      m_start = (m_q.size() > 0);
      else if (m_rem == 1) begin
        m_start = (m_q.size() > 0);
        if (!m_start) m_rem = 0;
      end else m_rem--;
      if (m_start) begin
        m_word = m_q.pop_front();
        m_d    = (div_i < 2) ? 2 : int'(div_i);
        m_par  = par_en_i;
        m_len  = (10 + int'(m_par)) * m_d;
        m_rem  = m_len;
      end
      if (wr_i && !m_full) m_q.push_back(data_i);
      if (wr_i && m_full)  m_ovf = 1'b1;
      else if (clr_ovf_i)  m_ovf = 1'b0;
    end
  end

  // Per-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge clk_i);
    check("cycle{tx,busy,done,full,empty,ovf}",
          32'({tx_o, busy_o, done_o, full_o, empty_o, ovf_o}),
          32'({exp_tx(), m_rem > 0, m_rem == 1, m_q.size() == FIFO_DEPTH, m_q.size() == 0, m_ovf}));
  end

  int busy_cnt = 0;
  int done_cnt = 0;
  initial forever begin
    @(negedge clk_i);
    if (busy_o) busy_cnt++;
    if (done_o) done_cnt++;
  end

  // ---------------- helpers (called at a negedge, return at a negedge) ----------------
  task automatic wr(input logic [7:0] d);
    data_i = d;
    wr_i   = 1'b1;
    @(negedge clk_i);
    wr_i   = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy_o || !empty_o) && t < 3000) begin
      @(negedge clk_i);
      t++;
    end
    check("wait_idle_timeout", 32'(t < 3000), 1);
    repeat (2) @(negedge clk_i);
  endtask

  task automatic wait_tx_low(output int t);
    t = 0;
    while (tx_o !== 1'b0 && t < 20) begin
      @(negedge clk_i);
      t++;
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    int          div;
    bit          par;
    int          nbits;
    logic [10:0] bits;   // bit k = k-th symbol on the line
    int          len;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input int vi, input vec_t v);
    int d, t, done_at, ndone;
    d = (v.div < 2) ? 2 : v.div;
    div_i    = DIV_W'(v.div);
    par_en_i = v.par;
    wr(v.data);
    wait_tx_low(t);
    check($sformatf("v%0d_latency", vi), t, 1);
    done_at = -1;
    ndone   = 0;
    for (int c = 0; c < v.len + d; c++) begin
      if (c < v.nbits * d && (c % d) == d / 2)
        check($sformatf("v%0d_bit%0d", vi, c / d), 32'(tx_o), 32'(v.bits[c / d]));
      if (done_o) begin
        done_at = c;
        ndone++;
      end
      @(negedge clk_i);
    end
    check($sformatf("v%0d_done_clock", vi), done_at, v.len - 1);
    check($sformatf("v%0d_done_count", vi), ndone, 1);
    wait_idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    rst_ni    = 1'b0;
    data_i    = '0;
    wr_i      = 1'b0;
    div_i     = DIV_W'(4);
    par_en_i  = 1'b0;
    clr_ovf_i = 1'b0;

    vecs[0] = '{data: 8'hA5, div: 4, par: 1'b0, nbits: 10, bits: 11'b01101001010, len: 40};
    vecs[1] = '{data: 8'h07, div: 3, par: 1'b1, nbits: 11, bits: 11'b11000001110, len: 33};
    vecs[2] = '{data: 8'h03, div: 3, par: 1'b1, nbits: 11, bits: 11'b10000000110, len: 33};
    vecs[3] = '{data: 8'h5A, div: 0, par: 1'b0, nbits: 10, bits: 11'b01010110100, len: 20};
    vecs[4] = '{data: 8'hFF, div: 1, par: 1'b0, nbits: 10, bits: 11'b01111111110, len: 20};

    repeat (3) @(negedge clk_i);
    check("rst_tx",    32'(tx_o),    1);
    check("rst_busy",  32'(busy_o),  0);
    check("rst_empty", 32'(empty_o), 1);
    check("rst_full",  32'(full_o),  0);
    check("rst_done",  32'(done_o),  0);
    check("rst_ovf",   32'(ovf_o),   0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // Single frames from the vector table.
    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Burst of five writes while idle, then overflow handling.
    div_i    = DIV_W'(8);
    par_en_i = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 5; i++) wr(8'h10 + 8'(i));
    check("burst_full", 32'(full_o), 1);
    wr(8'hEE);
    check("burst_ovf_set", 32'(ovf_o), 1);
    check("burst_still_full", 32'(full_o), 1);
    clr_ovf_i = 1'b1;
    wr(8'hEF);
    clr_ovf_i = 1'b0;
    check("ovf_set_wins", 32'(ovf_o), 1);
    clr_ovf_i = 1'b1;
    @(negedge clk_i);
    clr_ovf_i = 1'b0;
    check("ovf_cleared", 32'(ovf_o), 0);
    wait_idle();
    check("burst_busy_clocks", busy_cnt, 5 * 10 * 8);
    check("burst_done_pulses", done_cnt, 5);

    // Reset during data bit 3 of a frame with more words queued.
    div_i = DIV_W'(4);
    wr(8'h00);
    wait_tx_low(t);
    wr(8'hFF);
    wr(8'h3C);
    repeat (15) @(negedge clk_i);
    check("pre_reset_tx_low", 32'(tx_o), 0);
    #2 rst_ni = 1'b0;
    #1;
    check("midrst_tx",    32'(tx_o),    1);
    check("midrst_empty", 32'(empty_o), 1);
    check("midrst_busy",  32'(busy_o),  0);
    repeat (2) @(negedge clk_i);
    rst_ni   = 1'b1;
    busy_cnt = 0;
    repeat (60) @(negedge clk_i);
    check("post_rst_no_frame", busy_cnt, 0);
    check("post_rst_tx_idle", 32'(tx_o), 1);

    // Divider change mid-frame affects only the next frame.
    busy_cnt = 0;
    div_i    = DIV_W'(4);
    wr(8'hA5);
    wr(8'h5A);
    repeat (10) @(negedge clk_i);
    div_i = DIV_W'(6);
    wait_idle();
    check("divchg_busy_clocks", busy_cnt, 40 + 60);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      wr_i      = ($urandom_range(0, 5) == 0);
      data_i    = 8'($urandom);
      clr_ovf_i = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 15) == 0) div_i    = DIV_W'($urandom_range(0, 5));
      if ($urandom_range(0, 15) == 0) par_en_i = 1'($urandom);
      @(negedge clk_i);
    end
    wr_i      = 1'b0;
    clr_ovf_i = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
